fft_stage_ctrl: RTL and testbench

FFT_STAGE_CTRL -- requirements
Module: fft_stage_ctrl

---
 rtl/fft_pkg.sv | 15 +
 rtl/fft_stage_ctrl_if.sv | 38 +++
 rtl/fft_bf_addr.sv | 35 +++
 rtl/fft_stage_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_fft_stage_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage controller: FSM states and
// default address/twiddle widths.
package fft_pkg;

    localparam int ADDR_W_DEF = 11;
    localparam int TW_W_DEF   = 10;
    localparam int MAX_STAGES = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } fft_state_t;

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Butterfly command handshake between the stage controller and the
// downstream butterfly datapath.
interface fft_stage_ctrl_if
    import fft_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TW_W   = TW_W_DEF
);

    logic              bf_valid;
    logic              bf_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [ADDR_W-1:0] addr_b;
    logic [TW_W-1:0]   tw_idx;
    logic [3:0]        stage_idx;
    logic              last_bf;

    modport master (
        output bf_valid,
        output addr_a,
        output addr_b,
        output tw_idx,
        output stage_idx,
        output last_bf,
        input  bf_ready
    );

    modport slave (
        input  bf_valid,
        input  addr_a,
        input  addr_b,
        input  tw_idx,
        input  stage_idx,
        input  last_bf,
        output bf_ready
    );

endinterface

// File: rtl/fft_bf_addr.sv
// Radix-2 DIT butterfly address generator (bit-reversed in, natural out):
// maps stage s and butterfly b to the sample pair and twiddle exponent.
module fft_bf_addr
    import fft_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic [3:0]        s,
    input  logic [ADDR_W-2:0] b,
    input  logic [3:0]        stages,
    output logic [ADDR_W-1:0] addr_a,
    output logic [ADDR_W-1:0] addr_b,
    output logic [TW_W-1:0]   tw_idx
);

    logic [ADDR_W-1:0] bw;
    logic [ADDR_W-1:0] h;
    logic [ADDR_W-1:0] j;
    logic [ADDR_W-1:0] g;
    logic [3:0]        sh;

    assign bw = {1'b0, b};
    assign h  = ADDR_W'(1) << s;
    assign j  = bw & (h - ADDR_W'(1));
    assign g  = bw >> s;

    // group base is g * 2h, i.e. g shifted by s+1
    assign addr_a = ((g << s) << 1) | j;
    assign addr_b = addr_a + h;

    assign sh     = stages - s - 4'd1;
    assign tw_idx = TW_W'(j << sh);

endmodule

// File: rtl/fft_stage_ctrl.sv
// FFT stage controller: sequences all butterflies of an N-point radix-2
// FFT over a valid/ready command port, with parameter check and watchdog.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [3:0]            stage_number,
    input  logic [11:0]           max_point_fft,
    input  logic [15:0]           max_point_fft_core,
    fft_stage_ctrl_if.master      bf,
    output logic                  busy,
    output logic                  done,
    output logic                  param_err,
    output logic                  timeout_err
);

    localparam int BW = ADDR_W - 1;

    fft_state_t state_q, state_n;

    logic [3:0]    s_q, s_n;
    logic [BW-1:0] b_q, b_n;
    logic [3:0]    stages_q, stages_n;
    logic [11:0]   npts_q, npts_n;
    logic [15:0]   wd_lim_q, wd_lim_n;
    logic [15:0]   wd_q, wd_n;

    logic done_n;
    logic perr_n;
    logic tout_n;
    logic valid_n;
    logic last_n;

    logic params_ok;
    logic xfer;
    logic is_last;
    logic final_xfer;
    logic wd_hit;

    logic [BW-1:0] half_m1_q;
    logic [BW-1:0] half_m1_n;

    logic [ADDR_W-1:0] a_n;
    logic [ADDR_W-1:0] bb_n;
    logic [TW_W-1:0]   tw_n;

    assign params_ok = (stage_number != 4'd0)
                    && (stage_number <= 4'(MAX_STAGES))
                    && (max_point_fft == (12'd1 << stage_number));

    assign half_m1_q  = BW'((npts_q >> 1) - 12'd1);
    assign half_m1_n  = BW'((npts_n >> 1) - 12'd1);

    assign xfer       = bf.bf_valid && bf.bf_ready;
    assign is_last    = (b_q == half_m1_q);
    assign final_xfer = xfer && is_last
                     && (s_q == stages_q - 4'd1);
    assign wd_hit     = (wd_lim_q != 16'd0)
                     && (wd_q + 16'd1 == wd_lim_q);

    always_comb begin
        state_n  = state_q;
        s_n      = s_q;
        b_n      = b_q;
        stages_n = stages_q;
        npts_n   = npts_q;
        wd_lim_n = wd_lim_q;
        wd_n     = wd_q;
        done_n   = 1'b0;
        perr_n   = 1'b0;
        tout_n   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    stages_n = stage_number;
                    npts_n   = max_point_fft;
                    wd_lim_n = max_point_fft_core;
                    if (params_ok) begin
                        state_n = RUN;
                        s_n     = '0;
                        b_n     = '0;
                        wd_n    = '0;
                    end else begin
                        perr_n = 1'b1;
                    end
                end
            end
            RUN: begin
                wd_n = wd_q + 16'd1;
                if (xfer) begin
                    if (is_last) begin
                        s_n = s_q + 4'd1;
                        b_n = '0;
                    end else begin
                        b_n = b_q + BW'(1);
                    end
                end
                // the final transfer takes priority over the watchdog
                if (final_xfer) begin
                    state_n = FIN;
                    done_n  = 1'b1;
                    s_n     = '0;
                    b_n     = '0;
                    wd_n    = '0;
                end else if (wd_hit) begin
                    state_n = IDLE;
                    tout_n  = 1'b1;
                    s_n     = '0;
                    b_n     = '0;
                    wd_n    = '0;
                end
            end
            FIN: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign valid_n = (state_n == RUN);
    assign last_n  = valid_n && (b_n == half_m1_n);

    fft_bf_addr #(
        .ADDR_W (ADDR_W),
        .TW_W   (TW_W)
    ) u_addr (
        .s      (s_n),
        .b      (b_n),
        .stages (stages_n),
        .addr_a (a_n),
        .addr_b (bb_n),
        .tw_idx (tw_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            s_q          <= '0;
            b_q          <= '0;
            stages_q     <= '0;
            npts_q       <= '0;
            wd_lim_q     <= '0;
            wd_q         <= '0;
            bf.bf_valid  <= 1'b0;
            bf.addr_a    <= '0;
            bf.addr_b    <= '0;
            bf.tw_idx    <= '0;
            bf.stage_idx <= '0;
            bf.last_bf   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            param_err    <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state_q      <= state_n;
            s_q          <= s_n;
            b_q          <= b_n;
            stages_q     <= stages_n;
            npts_q       <= npts_n;
            wd_lim_q     <= wd_lim_n;
            wd_q         <= wd_n;
            bf.bf_valid  <= valid_n;
            bf.addr_a    <= valid_n ? a_n : '0;
            bf.addr_b    <= valid_n ? bb_n : '0;
            bf.tw_idx    <= valid_n ? tw_n : '0;
            bf.stage_idx <= valid_n ? s_n : '0;
            bf.last_bf   <= last_n;
            busy         <= valid_n;
            done         <= done_n;
            param_err    <= perr_n;
            timeout_err  <= tout_n;
        end
    end

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Scoreboard bench for fft_stage_ctrl: a loop-based DIT reference model
// queues expected commands, a negedge monitor checks every transfer.
module tb_fft_stage_ctrl;
    import fft_pkg::*;

    localparam int AW = 11;
    localparam int TW = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  stage_number = '0;
    logic [11:0] max_point_fft = '0;
    logic [15:0] max_point_fft_core = '0;
    logic        busy;
    logic        done;
    logic        param_err;
    logic        timeout_err;

    fft_stage_ctrl_if #(.ADDR_W(AW), .TW_W(TW)) bif ();

    fft_stage_ctrl #(.ADDR_W(AW), .TW_W(TW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .stage_number       (stage_number),
        .max_point_fft      (max_point_fft),
        .max_point_fft_core (max_point_fft_core),
        .bf                 (bif),
        .busy               (busy),
        .done               (done),
        .param_err          (param_err),
        .timeout_err        (timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        int tw;
        int st;
        int last;
    } cmd_t;

    cmd_t exp_q[$];

    int checks = 0;
    int failures = 0;
    int n_xfer = 0;
    int n_done = 0;
    int n_perr = 0;
    int n_tout = 0;
    int n_busy = 0;
    int n_valid = 0;
    int last_a = -1;
    int last_b = -1;
    int last_tw = -1;
    bit rand_ready = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, expv);
        end
    endtask

    // reference model: classic nested-loop DIT schedule
    task automatic push_run(input int ns, input int n);
        for (int s = 0; s < ns; s++) begin
            int h = 1 << s;
            int span = 2 * h;
            int idx = 0;
            for (int k = 0; k < n; k += span) begin
                for (int j = 0; j < h; j++) begin
                    cmd_t c;
                    c.a = k + j;
                    c.b = k + j + h;
                    c.tw = j * (n / span);
                    c.st = s;
                    c.last = (idx == n / 2 - 1) ? 1 : 0;
                    exp_q.push_back(c);
                    idx++;
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        bif.bf_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    logic          stall_p = 1'b0;
    logic [AW-1:0] ha, hb;
    logic [TW-1:0] ht;
    logic [3:0]    hs;
    logic          hl;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall_p = 1'b0;
        end else begin
            if (stall_p) begin
                chk("stall_valid", int'(bif.bf_valid), 1);
                chk("stall_payload",
                    int'({bif.addr_a, bif.addr_b, bif.tw_idx,
                          bif.stage_idx, bif.last_bf}
                         == {ha, hb, ht, hs, hl}), 1);
            end
            stall_p = bif.bf_valid && !bif.bf_ready;
            ha = bif.addr_a;
            hb = bif.addr_b;
            ht = bif.tw_idx;
            hs = bif.stage_idx;
            hl = bif.last_bf;
            if (bif.bf_valid && bif.bf_ready) begin
                n_xfer++;
                last_a = int'(bif.addr_a);
                last_b = int'(bif.addr_b);
                last_tw = int'(bif.tw_idx);
                if (exp_q.size() == 0) begin
                    chk("unexpected_xfer", 1, 0);
                end else begin
                    cmd_t e;
                    e = exp_q.pop_front();
                    chk("addr_a", int'(bif.addr_a), e.a);
                    chk("addr_b", int'(bif.addr_b), e.b);
                    chk("tw_idx", int'(bif.tw_idx), e.tw);
                    chk("stage_idx", int'(bif.stage_idx), e.st);
                    chk("last_bf", int'(bif.last_bf), e.last);
                end
            end
            if (done) n_done++;
            if (param_err) n_perr++;
            if (timeout_err) n_tout++;
            if (busy) n_busy++;
            if (bif.bf_valid) n_valid++;
        end
    end

    task automatic do_start(input int ns, input int n, input int wd);
        @(posedge clk);
        #1;
        stage_number = 4'(ns);
        max_point_fft = 12'(n);
        max_point_fft_core = 16'(wd);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        stage_number = 4'($urandom);
        max_point_fft = 12'($urandom);
        max_point_fft_core = 16'($urandom);
    endtask

    task automatic wait_end(input int budget, output int cyc);
        int d0 = n_done;
        int t0 = n_tout;
        cyc = 0;
        while (n_done == d0 && n_tout == t0 && cyc < budget) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("run_finished", int'((n_done != d0) || (n_tout != t0)), 1);
    endtask

    initial begin
        int cyc;
        int x0, d0, t0, p0, b0, v0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", int'(bif.bf_valid), 0);
        chk("rst_payload",
            int'({bif.addr_a, bif.addr_b, bif.tw_idx,
                  bif.stage_idx, bif.last_bf}), 0);
        chk("rst_status",
            int'({busy, done, param_err, timeout_err}), 0);
        #2;
        rst_n = 1'b1;

        // N=8 full-rate run
        rand_ready = 1'b0;
        x0 = n_xfer; d0 = n_done; t0 = n_tout;
        push_run(3, 8);
        do_start(3, 8, 0);
        wait_end(100, cyc);
        chk("done_latency", cyc, 13);
        chk("n8_xfers", n_xfer - x0, 12);
        chk("n8_done", n_done - d0, 1);
        chk("n8_no_tout", n_tout - t0, 0);
        chk("n8_queue", exp_q.size(), 0);

        // N=8 with stalls and a start attempt while running
        rand_ready = 1'b1;
        x0 = n_xfer; d0 = n_done;
        push_run(3, 8);
        do_start(3, 8, 0);
        start = 1'b1;
        stage_number = 4'd2;
        max_point_fft = 12'd4;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_end(500, cyc);
        chk("stall_xfers", n_xfer - x0, 12);
        chk("stall_done", n_done - d0, 1);
        chk("stall_queue", exp_q.size(), 0);

        // random sizes and handshake patterns
        for (int r = 0; r < 5; r++) begin
            int ns = int'($urandom_range(1, 6));
            rand_ready = 1'($urandom_range(0, 1));
            x0 = n_xfer; d0 = n_done;
            push_run(ns, 1 << ns);
            do_start(ns, 1 << ns, 0);
            wait_end(4000, cyc);
            chk("rnd_xfers", n_xfer - x0, ns * (1 << (ns - 1)));
            chk("rnd_done", n_done - d0, 1);
            chk("rnd_queue", exp_q.size(), 0);
        end

        // rejected parameter sets
        rand_ready = 1'b0;
        for (int r = 0; r < 3; r++) begin
            int ns = (r == 0) ? 3 : (r == 1) ? 0 : 12;
            int n  = (r == 0) ? 16 : (r == 1) ? 1 : 0;
            x0 = n_xfer; p0 = n_perr; b0 = n_busy; v0 = n_valid;
            do_start(ns, n, 0);
            repeat (6) @(negedge clk);
            #1;
            chk("perr_pulse", n_perr - p0, 1);
            chk("perr_busy", n_busy - b0, 0);
            chk("perr_valid", n_valid - v0, 0);
            chk("perr_xfers", n_xfer - x0, 0);
        end

        // watchdog expiry
        x0 = n_xfer; d0 = n_done; t0 = n_tout;
        push_run(3, 8);
        do_start(3, 8, 5);
        wait_end(100, cyc);
        repeat (3) @(negedge clk);
        #1;
        chk("wd_xfers", n_xfer - x0, 5);
        chk("wd_tout", n_tout - t0, 1);
        chk("wd_no_done", n_done - d0, 0);
        chk("wd_leftover", exp_q.size(), 7);
        chk("wd_idle", int'({busy, bif.bf_valid}), 0);
        exp_q.delete();

        // final transfer coincides with watchdog expiry
        x0 = n_xfer; d0 = n_done; t0 = n_tout;
        push_run(3, 8);
        do_start(3, 8, 12);
        wait_end(100, cyc);
        repeat (3) @(negedge clk);
        #1;
        chk("tie_xfers", n_xfer - x0, 12);
        chk("tie_done", n_done - d0, 1);
        chk("tie_no_tout", n_tout - t0, 0);

        // largest transform
        x0 = n_xfer; d0 = n_done;
        push_run(11, 2048);
        do_start(11, 2048, 0);
        wait_end(12000, cyc);
        chk("big_xfers", n_xfer - x0, 11264);
        chk("big_done", n_done - d0, 1);
        chk("big_last_a", last_a, 1023);
        chk("big_last_b", last_b, 2047);
        chk("big_last_tw", last_tw, 1023);
        chk("big_queue", exp_q.size(), 0);

        // asynchronous reset mid-run
        x0 = n_xfer; d0 = n_done;
        push_run(3, 8);
        do_start(3, 8, 0);
        cyc = 0;
        while (n_xfer - x0 < 4 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("pre_rst_xfers", n_xfer - x0, 4);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", int'(bif.bf_valid), 0);
        chk("arst_busy", int'(busy), 0);
        chk("arst_addr", int'({bif.addr_a, bif.addr_b}), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("arst_no_done", n_done - d0, 0);
        chk("arst_idle", int'(busy), 0);
        x0 = n_xfer;
        push_run(3, 8);
        do_start(3, 8, 0);
        wait_end(100, cyc);
        chk("rerun_xfers", n_xfer - x0, 12);
        chk("rerun_done", n_done - d0, 1);
        chk("rerun_queue", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
